// File: rtl/axi4_lite_reg_bank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  // Widest bus the bank supports; narrower buses use the low bits.
  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  // Replace the bytes of old_data whose strobe bit is set with new_data.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_data,
    input logic [MAX_DATA_WIDTH-1:0] new_data,
    input logic [MAX_STRB_WIDTH-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_data;
    for (int k = 0; k < MAX_STRB_WIDTH; k++) begin
      if (strb[k]) merged[k*8 +: 8] = new_data[k*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank_if.sv
// AXI4-Lite bus bundle between the bridge (master) and the register bank (slave).
interface axi4_lite_reg_bank_if
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_reg_bank_decode.sv
// Byte address to register index decoder; flags addresses outside the bank.
module axi4_lite_reg_decode
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  in_range
);

  localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // Word index relative to the bank base; sub-word address bits are dropped.
  always_comb begin
    offset   = addr - BASE_ADDR;
    word     = offset >> ALIGN_BITS;
    in_range = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
    idx      = word[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite slave register bank with per-register read-only selection,
// byte-strobe writes, SLVERR on illegal accesses and access pulses to hardware.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi4_lite_reg_bank_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_t             wr_state;
  rd_state_t             rd_state;

  logic                  aw_held;
  logic                  w_held;
  logic [IDX_WIDTH-1:0]  aw_idx_q;
  logic                  aw_in_range_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  resp_t                 bresp_q;
  logic                  arready_q;
  logic                  rvalid_q;
  resp_t                 rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IDX_WIDTH-1:0]  wr_dec_idx;
  logic                  wr_dec_in_range;
  logic [IDX_WIDTH-1:0]  rd_dec_idx;
  logic                  rd_dec_in_range;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  have_aw;
  logic                  have_w;
  logic                  wr_commit;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [NUM_REGS-1:0]   wr_sel;

  logic                  ar_fire;
  logic [NUM_REGS-1:0]   rd_sel;
  logic [DATA_WIDTH-1:0] rd_value;

  // Protection bits and the reg_in slices of writable registers carry no meaning here.
  logic                  unused_bits;
  assign unused_bits = ^{bus.awprot, bus.arprot, reg_in};

  axi4_lite_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_wr_decode (
    .addr     (bus.awaddr),
    .idx      (wr_dec_idx),
    .in_range (wr_dec_in_range)
  );

  axi4_lite_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_rd_decode (
    .addr     (bus.araddr),
    .idx      (rd_dec_idx),
    .in_range (rd_dec_in_range)
  );

  // Combine latched and just-arriving AW/W halves and pick the register a committing write hits.
  always_comb begin
    aw_fire     = bus.awvalid && awready_q;
    w_fire      = bus.wvalid && wready_q;
    have_aw     = aw_held || aw_fire;
    have_w      = w_held || w_fire;
    wr_commit   = (wr_state == W_IDLE) && have_aw && have_w;
    wr_idx      = aw_held ? aw_idx_q : wr_dec_idx;
    wr_in_range = aw_held ? aw_in_range_q : wr_dec_in_range;
    wr_data     = w_held ? w_data_q : bus.wdata;
    wr_strb     = w_held ? w_strb_q : bus.wstrb;
    wr_sel      = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_commit && wr_in_range && !RO_MASK[i] && (wr_idx == IDX_WIDTH'(i));
    end
  end

  // Write channel FSM: latch AW and W independently, commit once both are present, hold B until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state      <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      aw_in_range_q <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= OKAY;
      wr_pulse      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= wr_sel;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= DATA_WIDTH'(strb_merge(MAX_DATA_WIDTH'(regs[i]),
                                            MAX_DATA_WIDTH'(wr_data),
                                            MAX_STRB_WIDTH'(wr_strb)));
        end
      end
      case (wr_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_idx_q      <= wr_dec_idx;
            aw_in_range_q <= wr_dec_in_range;
          end
          if (w_fire) begin
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
          end
          if (wr_commit) begin
            bvalid_q  <= 1'b1;
            bresp_q   <= (|wr_sel) ? OKAY : SLVERR;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_state  <= W_RESP;
          end else begin
            aw_held   <= have_aw;
            w_held    <= have_w;
            awready_q <= !have_aw;
            wready_q  <= !have_w;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read data source: stored value for writable registers, hardware input for read-only ones.
  always_comb begin
    ar_fire  = bus.arvalid && arready_q;
    rd_sel   = '0;
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_dec_in_range && (rd_dec_idx == IDX_WIDTH'(i))) begin
        rd_sel[i] = 1'b1;
        rd_value  = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  // Read channel FSM: capture data on the AR handshake and hold R until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      rd_pulse  <= '0;
    end else begin
      rd_pulse <= '0;
      case (rd_state)
        R_IDLE: begin
          if (ar_fire) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_value;
            rresp_q   <= (|rd_sel) ? OKAY : SLVERR;
            rd_pulse  <= rd_sel;
            arready_q <= 1'b0;
            rd_state  <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Randomised self-checking bench for the AXI4-Lite register bank, compared
// against a byte-level array model of the register file.
module tb_axi4_lite_reg_bank;
  import axi4_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = DW / 8;
  localparam logic [NR-1:0] RO = 16'h0208;

  logic clk;
  logic rst;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0] wr_pulse;
  logic [NR-1:0] rd_pulse;

  axi4_lite_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_reg_bank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .BASE_ADDR  (32'h0),
    .RO_MASK    (RO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .reg_out  (reg_out),
    .reg_in   (reg_in),
    .wr_pulse (wr_pulse),
    .rd_pulse (rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mdl_regs [NR];
  logic [DW-1:0] mdl_in [NR];
  int checks;
  int errors;
  logic [DW-1:0] old_val;
  logic [DW-1:0] new_val;
  logic [AW-1:0] rnd_addr;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // The bank sits at base 0, so the index is simply the word number.
  function automatic void modelDecode(input logic [AW-1:0] addr, output int idx, output bit in_range);
    longint unsigned word;
    word = 64'(addr) / SW;
    in_range = word < NR;
    idx = in_range ? int'(word) : -1;
  endfunction

  task automatic modelWrite(input int idx, input logic [DW-1:0] data, input logic [SW-1:0] strb);
    for (int k = 0; k < SW; k++) begin
      if (strb[k]) mdl_regs[idx][k*8 +: 8] = data[k*8 +: 8];
    end
  endtask

  task automatic setRegIn(input int i, input logic [DW-1:0] v);
    mdl_in[i] = v;
    reg_in[i*DW +: DW] = v;
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < NR; i++) begin
      checkOutput($sformatf("%s reg_out[%0d]", tag, i), 64'(reg_out[i*DW +: DW]), 64'(mdl_regs[i]));
    end
  endtask

  // lead > 0: W is presented lead cycles before AW; lead < 0: AW goes first.
  task automatic writeTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int lead, input int hold);
    int idx;
    bit in_range;
    bit ok;
    int aw_start;
    int w_start;
    bit aw_done;
    bit w_done;
    bit will_aw;
    bit will_w;
    logic [NR-1:0] exp_pulse;
    logic [1:0] exp_resp;
    modelDecode(addr, idx, in_range);
    ok = 1'b0;
    if (in_range) ok = (RO[idx] == 1'b0);
    aw_start = (lead > 0) ? lead : 0;
    w_start = (lead < 0) ? -lead : 0;
    aw_done = 1'b0;
    w_done = 1'b0;
    bus.awaddr = addr;
    bus.awprot = 3'($urandom_range(0, 7));
    bus.wdata = data;
    bus.wstrb = strb;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (aw_done && w_done) break;
      bus.awvalid = (cyc >= aw_start) && !aw_done;
      bus.wvalid = (cyc >= w_start) && !w_done;
      if (aw_done) checkOutput("awready while W pending", 64'(bus.awready), 64'd0);
      if (w_done) checkOutput("wready while AW pending", 64'(bus.wready), 64'd0);
      will_aw = bus.awvalid && bus.awready;
      will_w = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (will_aw) aw_done = 1'b1;
      if (will_w) w_done = 1'b1;
    end
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      checkOutput("write handshake timeout", 64'd0, 64'd1);
      return;
    end
    if (ok) modelWrite(idx, data, strb);
    exp_pulse = '0;
    if (ok) exp_pulse[idx] = 1'b1;
    exp_resp = ok ? 2'b00 : 2'b10;
    checkOutput("bvalid after write", 64'(bus.bvalid), 64'd1);
    checkOutput("bresp", 64'(bus.bresp), 64'(exp_resp));
    checkOutput("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
    checkOutput("readies during B", 64'({bus.awready, bus.wready}), 64'd0);
    checkAllRegs("after write");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("bvalid held", 64'(bus.bvalid), 64'd1);
      checkOutput("bresp held", 64'(bus.bresp), 64'(exp_resp));
      checkOutput("readies held low", 64'({bus.awready, bus.wready}), 64'd0);
      checkOutput("wr_pulse single cycle", 64'(wr_pulse), 64'd0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    checkOutput("bvalid cleared", 64'(bus.bvalid), 64'd0);
    checkOutput("wr_pulse cleared", 64'(wr_pulse), 64'd0);
    checkOutput("readies back", 64'({bus.awready, bus.wready}), 64'd3);
  endtask

  task automatic readTxn(input logic [AW-1:0] addr, input int hold);
    int idx;
    bit in_range;
    bit done;
    bit will_ar;
    logic [DW-1:0] exp_data;
    logic [NR-1:0] exp_pulse;
    logic [1:0] exp_resp;
    modelDecode(addr, idx, in_range);
    exp_data = '0;
    exp_pulse = '0;
    exp_resp = 2'b10;
    if (in_range) begin
      exp_data = RO[idx] ? mdl_in[idx] : mdl_regs[idx];
      exp_pulse[idx] = 1'b1;
      exp_resp = 2'b00;
    end
    done = 1'b0;
    bus.araddr = addr;
    bus.arprot = 3'($urandom_range(0, 7));
    bus.arvalid = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      will_ar = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      if (will_ar) begin
        done = 1'b1;
        break;
      end
    end
    bus.arvalid = 1'b0;
    if (!done) begin
      checkOutput("read handshake timeout", 64'd0, 64'd1);
      return;
    end
    checkOutput("rvalid after read", 64'(bus.rvalid), 64'd1);
    checkOutput("rdata", 64'(bus.rdata), 64'(exp_data));
    checkOutput("rresp", 64'(bus.rresp), 64'(exp_resp));
    checkOutput("rd_pulse", 64'(rd_pulse), 64'(exp_pulse));
    checkOutput("arready during R", 64'(bus.arready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("rvalid held", 64'(bus.rvalid), 64'd1);
      checkOutput("rdata held", 64'(bus.rdata), 64'(exp_data));
      checkOutput("rresp held", 64'(bus.rresp), 64'(exp_resp));
      checkOutput("arready held low", 64'(bus.arready), 64'd0);
      checkOutput("rd_pulse single cycle", 64'(rd_pulse), 64'd0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    checkOutput("rvalid cleared", 64'(bus.rvalid), 64'd0);
    checkOutput("rd_pulse cleared", 64'(rd_pulse), 64'd0);
    checkOutput("arready back", 64'(bus.arready), 64'd1);
  endtask

  task automatic applyStimulus(input bit is_write, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] strb, input int lead, input int hold);
    if (is_write) writeTxn(addr, data, strb, lead, hold);
    else readTxn(addr, hold);
  endtask

  // Hang guard: a stuck run still reports and stops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    reg_in = '0;
    for (int i = 0; i < NR; i++) begin
      mdl_regs[i] = '0;
      setRegIn(i, $urandom);
    end
    setRegIn(3, 32'hCAFE0001);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset awready", 64'(bus.awready), 64'd0);
    checkOutput("reset wready", 64'(bus.wready), 64'd0);
    checkOutput("reset arready", 64'(bus.arready), 64'd0);
    checkOutput("reset bvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("reset rvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("reset bresp", 64'(bus.bresp), 64'd0);
    checkOutput("reset rresp", 64'(bus.rresp), 64'd0);
    checkOutput("reset rdata", 64'(bus.rdata), 64'd0);
    checkOutput("reset wr_pulse", 64'(wr_pulse), 64'd0);
    checkOutput("reset rd_pulse", 64'(rd_pulse), 64'd0);
    checkAllRegs("reset");

    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("readies after reset release", 64'({bus.awready, bus.wready, bus.arready}), 64'd7);

    $display("[TB] directed sequences");
    applyStimulus(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    checkOutput("reg1 full write", 64'(reg_out[1*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    applyStimulus(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, -1, 0);
    applyStimulus(1'b1, 32'h08, 32'h12345678, 4'h3, 3, 0);
    checkOutput("reg2 strobed write", 64'(reg_out[2*DW +: DW]), 64'h0000_0000_FFFF_5678);
    applyStimulus(1'b1, 32'h0C, 32'h11112222, 4'hF, -2, 0);
    applyStimulus(1'b0, 32'h0C, '0, '0, 0, 0);
    applyStimulus(1'b0, 32'h40, '0, '0, 0, 0);
    applyStimulus(1'b1, 32'h40, 32'h55AA55AA, 4'hF, 0, 0);
    applyStimulus(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 5);
    applyStimulus(1'b0, 32'h10, '0, '0, 0, 5);
    applyStimulus(1'b1, 32'h18, 32'h0BADF00D, 4'hF, 0, 0);
    applyStimulus(1'b1, 32'h18, 32'hFFFFFFFF, 4'h0, 0, 0);
    applyStimulus(1'b0, 32'h07, '0, '0, 0, 0);
    applyStimulus(1'b1, 32'h3C, 32'h87654321, 4'hC, 1, 1);
    applyStimulus(1'b0, 32'h3C, '0, '0, 0, 0);
    applyStimulus(1'b0, 32'h24, '0, '0, 0, 2);

    // Read and write commit to the same register on the same edge.
    applyStimulus(1'b1, 32'h14, 32'h13579BDF, 4'hF, 0, 0);
    old_val = mdl_regs[5];
    new_val = $urandom;
    bus.awaddr = 32'h14; bus.wdata = new_val; bus.wstrb = 4'hF; bus.araddr = 32'h14;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checkOutput("same-edge rvalid", 64'(bus.rvalid), 64'd1);
    checkOutput("same-edge rdata is old", 64'(bus.rdata), 64'(old_val));
    checkOutput("same-edge bvalid", 64'(bus.bvalid), 64'd1);
    checkOutput("same-edge rd_pulse", 64'(rd_pulse), 64'h20);
    checkOutput("same-edge wr_pulse", 64'(wr_pulse), 64'h20);
    mdl_regs[5] = new_val;
    checkOutput("same-edge reg5 updated", 64'(reg_out[5*DW +: DW]), 64'(new_val));
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    checkOutput("same-edge responses done", 64'({bus.bvalid, bus.rvalid}), 64'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) setRegIn(int'($urandom_range(0, NR - 1)), $urandom);
      if ($urandom_range(0, 9) == 0) rnd_addr = $urandom;
      else rnd_addr = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), rnd_addr, $urandom, SW'($urandom_range(0, 15)),
                    int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
    end

    $display("[TB] reset during pending response");
    bus.awaddr = 32'h20; bus.wdata = $urandom; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checkOutput("pre-reset bvalid", 64'(bus.bvalid), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset bvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("async reset wr_pulse", 64'(wr_pulse), 64'd0);
    checkOutput("async reset readies", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
    for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
    checkAllRegs("async reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h20, 32'h600DCAFE, 4'hF, 1, 1);
    applyStimulus(1'b0, 32'h20, '0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
